// File: rtl/ascon_pkg.sv
// Shared widths, round-constant table and FSM encoding for the Ascon-style
// forward and inverse permutation blocks.
package ascon_pkg;

  localparam int STATE_W = 128;
  localparam int RC_W    = 5;
  localparam int ROUND_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } fsmState_t;

  // Single source of round constants for both directions; indices 12..15 carry no constant.
  function automatic logic [RC_W-1:0] rc_of(input logic [ROUND_W-1:0] round);
    logic [RC_W-1:0] rc;
    case (round)
      4'd0:    rc = 5'h10;
      4'd1:    rc = 5'h01;
      4'd2:    rc = 5'h12;
      4'd3:    rc = 5'h03;
      4'd4:    rc = 5'h14;
      4'd5:    rc = 5'h05;
      4'd6:    rc = 5'h16;
      4'd7:    rc = 5'h07;
      4'd8:    rc = 5'h18;
      4'd9:    rc = 5'h09;
      4'd10:   rc = 5'h1A;
      4'd11:   rc = 5'h0B;
      default: rc = 5'h00;
    endcase
    return rc;
  endfunction

  function automatic logic [STATE_W-1:0] fwd_round(input logic [STATE_W-1:0] state,
                                                   input logic [ROUND_W-1:0] round);
    logic [STATE_W-1:0] t;
    t = state ^ {{(STATE_W-RC_W){1'b0}}, rc_of(round)};
    return t ^ (t >> 8);
  endfunction

endpackage

// File: rtl/ascon_inv_round.sv
// One combinational inverse round: undoes t ^ (t >> 8) with a byte prefix XOR
// from the MSB downward, then strips the round constant.
module ascon_inv_round
  import ascon_pkg::*;
(
  input  logic [STATE_W-1:0] i_y,
  input  logic [ROUND_W-1:0] i_round,
  output logic [STATE_W-1:0] o_x
);

  function automatic logic [STATE_W-1:0] prefixXor(input logic [STATE_W-1:0] y);
    logic [STATE_W-1:0] t;
    t = '0;
    t[STATE_W-1 -: 8] = y[STATE_W-1 -: 8];
    for (int k = (STATE_W / 8) - 2; k >= 0; k--) begin
      t[k*8 +: 8] = y[k*8 +: 8] ^ t[(k+1)*8 +: 8];
    end
    return t;
  endfunction

  logic [STATE_W-1:0] w_t;

  assign w_t = prefixXor(i_y);
  assign o_x = w_t ^ {{(STATE_W-RC_W){1'b0}}, rc_of(i_round)};

endmodule

// File: rtl/ascon_inv_permutation.sv
// Iterative inverse permutation: one inverse round per clock, walking round
// indices downward from r0+N-1 to r0, with valid/ready on both sides.
module ascon_inv_permutation
  import ascon_pkg::*;
#(
  parameter int MAX_ROUNDS = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_state,
  input  logic [ROUND_W-1:0] in_start_round,
  input  logic [ROUND_W-1:0] in_num_rounds,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_state,
  output logic               busy,
  input  logic               flush
);

  localparam logic [ROUND_W-1:0] MAX_R = ROUND_W'(MAX_ROUNDS);

  fsmState_t          r_fsm;
  fsmState_t          w_nextFsm;
  logic [STATE_W-1:0] r_data;
  logic [STATE_W-1:0] r_outState;
  logic [ROUND_W-1:0] r_r0;
  logic [ROUND_W-1:0] r_cnt;
  logic [ROUND_W-1:0] w_numClamped;
  logic [ROUND_W-1:0] w_roundIdx;
  logic [STATE_W-1:0] w_invOut;
  logic               w_fire;

  assign w_numClamped = (in_num_rounds > MAX_R) ? MAX_R : in_num_rounds;
  assign w_roundIdx   = r_r0 + r_cnt - 4'd1;
  assign w_fire       = in_valid & in_ready & ~flush;

  ascon_inv_round u_invRound (
    .i_y     (r_data),
    .i_round (w_roundIdx),
    .o_x     (w_invOut)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_fsm <= IDLE;
    else        r_fsm <= w_nextFsm;
  end

  // flush overrides every other transition, including a pending input fire.
  always_comb begin
    w_nextFsm = r_fsm;
    case (r_fsm)
      IDLE:    if (w_fire) w_nextFsm = (w_numClamped == '0) ? DONE : RUN;
      RUN:     if (r_cnt == 4'd1) w_nextFsm = DONE;
      DONE:    if (out_ready) w_nextFsm = IDLE;
      default: w_nextFsm = IDLE;
    endcase
    if (flush) w_nextFsm = IDLE;
  end

  always_comb begin
    in_ready  = (r_fsm == IDLE);
    out_valid = (r_fsm == DONE);
    busy      = (r_fsm == RUN) || (r_fsm == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data     <= '0;
      r_outState <= '0;
      r_r0       <= '0;
      r_cnt      <= '0;
    end else begin
      case (r_fsm)
        IDLE: begin
          if (w_fire) begin
            r_data <= in_state;
            r_r0   <= in_start_round;
            r_cnt  <= w_numClamped;
            if (w_numClamped == '0) r_outState <= in_state;
          end
        end
        RUN: begin
          if (!flush) begin
            r_data <= w_invOut;
            r_cnt  <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) r_outState <= w_invOut;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_state = r_outState;

endmodule

// File: tb/tb_ascon_inv_permutation.sv
// Directed bench for ascon_inv_permutation: hand-computed vectors plus an
// independent forward-round model to confirm forward(inverse(x)) == x.
module tb_ascon_inv_permutation;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic [3:0]   in_start_round;
  logic [3:0]   in_num_rounds;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;
  logic         flush;

  int checks;
  int errors;

  ascon_inv_permutation #(.MAX_ROUNDS(12)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_state       (in_state),
    .in_start_round (in_start_round),
    .in_num_rounds  (in_num_rounds),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_state      (out_state),
    .busy           (busy),
    .flush          (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] rcModel(input logic [3:0] r);
    case (r)
      4'd0: return 5'h10;  4'd1: return 5'h01;  4'd2:  return 5'h12; 4'd3:  return 5'h03;
      4'd4: return 5'h14;  4'd5: return 5'h05;  4'd6:  return 5'h16; 4'd7:  return 5'h07;
      4'd8: return 5'h18;  4'd9: return 5'h09;  4'd10: return 5'h1A; 4'd11: return 5'h0B;
      default: return 5'h00;
    endcase
  endfunction

  function automatic logic [127:0] fwdChain(input logic [127:0] x, input logic [3:0] r0,
                                            input int n);
    logic [127:0] t;
    logic [3:0]   r;
    r = r0;
    for (int i = 0; i < n; i++) begin
      t = x ^ {123'h0, rcModel(r)};
      x = t ^ (t >> 8);
      r = r + 4'd1;
    end
    return x;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [127:0] st, input logic [3:0] r0,
                               input logic [3:0] n);
    @(negedge clk);
    in_valid       = 1'b1;
    in_state       = st;
    in_start_round = r0;
    in_num_rounds  = n;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic waitValid(input string tag, output int lat);
    bit found;
    found = 0;
    lat   = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      lat++;
      if (out_valid === 1'b1) found = 1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s timeout: observed no out_valid, expected out_valid within 40 cycles", tag);
    end
  endtask

  task automatic acceptOutput(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    checkOutput({tag, "_inReadyAfterAccept"}, {127'h0, in_ready}, 128'h1);
  endtask

  task automatic runJob(input string tag, input logic [127:0] st, input logic [3:0] r0,
                        input logic [3:0] n, input int expLat, input logic [127:0] expState);
    int lat;
    applyStimulus(st, r0, n);
    waitValid(tag, lat);
    checkOutput({tag, "_latency"}, 128'(lat), 128'(expLat));
    checkOutput(tag, out_state, expState);
    acceptOutput(tag);
  endtask

  task automatic runRoundTrip(input string tag, input logic [127:0] st, input logic [3:0] r0,
                              input logic [3:0] n, input int rounds, input int expLat);
    int lat;
    applyStimulus(st, r0, n);
    waitValid(tag, lat);
    checkOutput({tag, "_latency"}, 128'(lat), 128'(expLat));
    checkOutput({tag, "_fwdOfInv"}, fwdChain(out_state, r0, rounds), st);
    acceptOutput(tag);
  endtask

  initial begin
    logic [127:0] rnd;
    logic [127:0] held;
    bit           bad;
    int           lat;

    checks = 0;
    errors = 0;
    rst_n          = 1'b1;
    in_valid       = 1'b0;
    in_state       = '0;
    in_start_round = '0;
    in_num_rounds  = '0;
    out_ready      = 1'b0;
    flush          = 1'b0;

    #3 rst_n = 1'b0;
    #4;
    checkOutput("reset_inReady", {127'h0, in_ready}, 128'h1);
    checkOutput("reset_outValid", {127'h0, out_valid}, 128'h0);
    checkOutput("reset_busy", {127'h0, busy}, 128'h0);
    checkOutput("reset_outState", out_state, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;

    runJob("singleZero", 128'h0, 4'd0, 4'd1, 2, 128'h10);
    runJob("byteCascade", {8'hAA, 120'h0}, 4'd0, 4'd1, 2,
           128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AABA);
    runJob("twoRounds", 128'h0, 4'd0, 4'd2, 3, 128'h11);
    checkOutput("twoRounds_fwd", fwdChain(128'h11, 4'd0, 2), 128'h0);
    runJob("passThrough", 128'h1234, 4'd5, 4'd0, 1, 128'h1234);
    runJob("wrapIndex", 128'h0, 4'd10, 4'd4, 5, 128'h11);

    rnd = {$urandom, $urandom, $urandom, $urandom};
    runRoundTrip("clamp15", rnd, 4'd3, 4'd15, 12, 13);
    for (int i = 0; i < 3; i++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      runRoundTrip("random12", rnd, 4'(i), 4'd12, 12, 13);
    end
    rnd = {$urandom, $urandom, $urandom, $urandom};
    runRoundTrip("wrapRandom", rnd, 4'd10, 4'd4, 4, 5);

    // Backpressure: a new request arriving while DONE must not disturb the result.
    applyStimulus({8'hAA, 120'h0}, 4'd0, 4'd1);
    waitValid("backpressure", lat);
    held = 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AABA;
    in_valid = 1'b1;
    in_state = 128'hDEAD_BEEF;
    in_num_rounds = 4'd1;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_state !== held || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1)
        bad = 1;
    end
    checkOutput("backpressure_hold", {127'h0, bad}, 128'h0);
    in_valid = 1'b0;
    acceptOutput("backpressure");
    checkOutput("backpressure_idleBusy", {127'h0, busy}, 128'h0);
    checkOutput("backpressure_idleOutState", out_state, held);

    // Async reset in the middle of a long job.
    applyStimulus(128'h0, 4'd0, 4'd12);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midReset_inReady", {127'h0, in_ready}, 128'h1);
    checkOutput("midReset_outValid", {127'h0, out_valid}, 128'h0);
    checkOutput("midReset_busy", {127'h0, busy}, 128'h0);
    checkOutput("midReset_outState", out_state, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad = 1;
    end
    checkOutput("midReset_noOutput", {127'h0, bad}, 128'h0);

    // flush in IDLE must swallow a simultaneous request.
    @(negedge clk);
    in_valid = 1'b1;
    flush = 1'b1;
    in_state = 128'h77;
    in_num_rounds = 4'd1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush = 1'b0;
    checkOutput("flushIdle_busy", {127'h0, busy}, 128'h0);
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad = 1;
    end
    checkOutput("flushIdle_noOutput", {127'h0, bad}, 128'h0);

    // flush mid-RUN, then a clean job afterwards.
    applyStimulus(128'h0, 4'd0, 4'd12);
    repeat (3) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    checkOutput("flushRun_busy", {127'h0, busy}, 128'h0);
    checkOutput("flushRun_inReady", {127'h0, in_ready}, 128'h1);
    bad = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad = 1;
    end
    checkOutput("flushRun_noOutput", {127'h0, bad}, 128'h0);
    runJob("afterFlush", 128'h0, 4'd0, 4'd1, 2, 128'h10);

    // flush while DONE drops out_valid.
    applyStimulus(128'h55, 4'd0, 4'd0);
    waitValid("flushDone", lat);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    checkOutput("flushDone_outValid", {127'h0, out_valid}, 128'h0);
    checkOutput("flushDone_inReady", {127'h0, in_ready}, 128'h1);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ascon_inv_permutation.md
Name: ascon_inv_permutation

Overview:
- Iterative inverse of the team's round function `state_out = t ^ (t >> 8)`, where `t = state_in ^ {120'h0, RC[r]}`.
- Undoes a sequence of forward rounds, one inverse round per clock, in descending round order.
- Sits on the decrypt/verify path. It takes a permuted 128-bit state and returns the pre-permutation state.
- Uses valid/ready handshakes on both sides.

Parameters:
- MAX_ROUNDS, 12, upper limit on the round count; a larger in_num_rounds is clamped to this value.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  input state and job fields are valid
- in_ready  output  1  block can accept a job
- in_state  input  128  permuted state to invert
- in_start_round  input  4  first forward round index r0
- in_num_rounds  input  4  number of forward rounds N that were applied
- out_valid  output  1  out_state is valid
- out_ready  input  1  consumer accepts out_state
- out_state  output  128  recovered pre-permutation state
- busy  output  1  high while in RUN or DONE
- flush  input  1  synchronous abort; returns to IDLE

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE; state register, round counter and out_state are 0.
  - Outputs: in_ready=1, out_valid=0, busy=0.
- Reset mid-operation discards the job completely; no output is produced.
- Round constants RC[0..11], 5-bit values: 10,01,12,03,14,05,16,07,18,09,1A,0B (hex). RC[12..15]=0.
- Inverse round r on state y:
  - Recover t: top byte t[127:120] = y[127:120]; every lower byte t[k] = y[k] ^ t[k+1]. This is a prefix XOR of bytes from the MSB down.
  - Result x = t ^ {123'h0, RC[r]}.
  - Purely combinational, no carries.
- FSM: IDLE -> RUN -> DONE -> IDLE.
  - IDLE: in_ready=1. On in_valid&in_ready (fire):
    - Latch in_state, r0, and N = min(in_num_rounds, MAX_ROUNDS).
    - If N=0, go directly to DONE with out_state=in_state (pass-through).
    - Otherwise load cnt=N and go to RUN.
  - RUN: in_ready=0. Each cycle apply the inverse round with index (r0+cnt-1) mod 16, then decrement cnt. On the cycle cnt reaches 0, go to DONE.
  - DONE: out_valid=1 and out_state is held stable until out_ready.
    - On out_valid&out_ready, go to IDLE. in_ready rises the next cycle; a same-cycle accept is not supported.
- Latency:
  - in fire edge to out_valid = N+1 cycles for N>=1.
  - N=0 gives out_valid 1 cycle after fire.
  - Throughput: one job per N+2 cycles minimum.
- Backpressure: out_ready low in DONE holds out_state/out_valid indefinitely; the input stays blocked.
- Round index arithmetic is 4-bit, wrap mod 16. Example: r0=10, N=4 uses indices 13,12,11,10, and 13/12 use RC=0.
- flush:
  - Has priority over all transitions; goes to IDLE next cycle and deasserts out_valid.
  - flush in IDLE with in_valid high: no job accepted.
- in_valid while not in_ready: ignored; the input side must hold it.
- out_state in IDLE/RUN: holds the last delivered value (0 after reset); not meaningful unless out_valid=1.

Decomposition:
- Shared package ascon_pkg:
  - STATE_W=128, RC_W=5, ROUND_W=4.
  - RC table as a constant function rc_of(round) returning 0 for indices >=12.
  - FSM state typedef {IDLE,RUN,DONE}.
- The forward permutation block must take its constants from rc_of, so both directions stay consistent.
- One sub-module: ascon_inv_round, a combinational single inverse round (inputs y, round index; output x). Instantiated once inside the iterative FSM.

Test Plan:
- Single round, zero state: in_state=0, r0=0, N=1 -> out_state=128'h10, out_valid 2 cycles after fire.
- Byte cascade: in_state={8'hAA,120'h0}, r0=0, N=1 -> out_state=128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AABA.
- Multi-round order: in_state=0, r0=0, N=2 -> inverse round 1 then round 0 gives 128'h11. Chaining this through the forward block's rounds 0 then 1 gives 0. Also run N=12 on random states: forward(inverse(x)) == x.
- Edge counts:
  - N=0 with in_state=128'h1234 -> out_state=128'h1234 after 1 cycle.
  - in_num_rounds=15 -> clamped to 12 rounds: out_valid at 13 cycles.
  - r0=10, N=4 -> uses RC 0,0,0B,1A.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_state stable, in_ready=0, new in_valid ignored. On release: handshake completes and in_ready=1 the next cycle.
- Abort paths:
  - Assert rst_n=0 mid-RUN -> all outputs reset immediately, no out_valid afterwards.
  - Assert flush mid-RUN -> IDLE next cycle, out_valid never rises, and the next job completes correctly.
